ascon_serial_io: RTL
====================

// Module: ascon_serial_io
// PURPOSE
//  Pin-level serial front-end for the Ascon AEAD core.
//  - Shifts key, nonce, associated data, text and (optionally) an expected tag in from GPIO pins,
//    LANES bits per strobe, and presents them in parallel to the core.
//  - Issues the core start pulse and captures the core's text/tag result.
//  - Shifts the result back out serially and raises ready.
//  - Generalises the fixed 1-bit, fixed-length serial interface to configurable widths and lane count.
// PARAMETERS
//  KEY_W   128  key width, bits
//  NONCE_W 128  nonce width, bits
//  AD_W    40   associated-data width, bits
//  DATA_W  104  plaintext/ciphertext width, bits
//  TAG_W   128  tag width, bits
//  LANES   1    bits per strobe per stream, 1/2/4/8; every *_W is a multiple of LANES
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  shift_i      in   1       load strobe in LOAD, unload strobe in UNLOAD
//  key_si       in   LANES   serial key, MSB first
//  nonce_si     in   LANES   serial nonce, MSB first
//  ad_si        in   LANES   serial associated data, MSB first
//  data_si      in   LANES   serial PT (encrypt) or CT (decrypt), MSB first
//  tag_si       in   LANES   serial expected tag (used only with TAG_CHECK_EN)
//  start_i      in   1       start request, level, rising edge used
//  decrypt_i    in   1       0 = encrypt, 1 = decrypt; latched on accepted start
//  key_o        out  KEY_W   parallel key to core
//  nonce_o      out  NONCE_W parallel nonce to core
//  ad_o         out  AD_W    parallel AD to core
//  data_o       out  DATA_W  parallel text to core
//  decrypt_o    out  1       latched mode to core
//  core_start_o out  1       one-cycle start pulse to core
//  core_ready_i in   1       core result valid (level)
//  core_data_i  in   DATA_W  core output text
//  core_tag_i   in   TAG_W   core output tag
//  data_so      out  LANES   serial text out, MSB first
//  tag_so       out  LANES   serial tag out, MSB first
//  ready_so     out  1       result available
//  busy_o       out  1       high in WAIT_CORE and UNLOAD
//  load_done_o  out  1       all input streams fully loaded
//  err_o        out  1       sticky protocol error
//  auth_ok_o    out  1       tag check passed (TAG_CHECK_EN only)
// BEHAVIOUR
//  Reset: all outputs and registers 0; state LOAD; load beat counter 0.
//  Beats and streams
//  - BEATS = max(KEY_W,NONCE_W,AD_W,DATA_W,TAG_W)/LANES.
//  - Each stream shifts left by LANES on a shift_i beat only while beat count < its own W/LANES.
//    Shorter streams then hold their value.
//  - load_done_o=1 once beat count = BEATS; the counter saturates there.
//  Start detect
//  - Registered start_q; edge = start_i & ~start_q.
//  - A start held for many cycles is one request.
//  States
//  - LOAD: edge with load_done_o=1 -> WAIT_CORE.
//    On that edge: core_start_o=1 for exactly one cycle (the next cycle), decrypt_o<=decrypt_i.
//    Edge with load_done_o=0: err_o<=1, stay in LOAD, no pulse.
//  - WAIT_CORE: busy_o=1. When core_ready_i=1, capture core_data_i and core_tag_i into the output
//    shifters, then -> UNLOAD. ready_so=1 from the next cycle.
//  - UNLOAD:
//    - data_so/tag_so present the top LANES bits.
//    - Each shift_i shifts left and inserts 0.
//    - The data stream ends after DATA_W/LANES beats; the tag stream after TAG_W/LANES beats.
//    - After max of the two -> DONE.
//  - DONE: busy_o=0, ready_so held 1. A start edge clears the counters, load_done_o and ready_so,
//    and goes to LOAD; it does NOT start the core.
//  Errors and reset
//  - A start edge in WAIT_CORE or UNLOAD is ignored and sets err_o. Only rst clears err_o.
//  - rst mid-operation: immediate clear of all state and outputs; an in-flight core result is discarded.
//  - shift_i in WAIT_CORE or DONE: no effect.
// CONFIGURATION
//  Macro ASCON_SERIAL_TAG_CHECK_EN.
//  Defined:
//  - tag_si loads an expected-tag register, like the other streams.
//  - When decrypt_o=1, on capture: auth_ok_o <= (core_tag_i == expected tag).
//  - On mismatch the captured text is zeroed, so data_so emits all zeros.
//  - In encrypt mode auth_ok_o stays 0.
//  Undefined: tag_si ignored, auth_ok_o tied 0, text always released.
// TESTING
//  1. LANES=1; 128 strobes with key 0x6d4f8bbf60ec05a07b201d4e5b2119ac, nonce 0x05885e606e1271b8d47a74c7b297a318,
//     AD 0x4153434f4e, PT 0x6173636f6e2d756e6963617373
//     -> outputs equal the inputs; load_done_o=1 after beat 128, not before.
//  2. start_i high 5 cycles after load; stub core ready 20 cycles later with CT 0x18490112f8d5867a830748390b
//     -> single core_start_o pulse; ready_so next cycle; 104 strobes shift out that CT MSB first.
//  3. Start edge at load beat 50 -> err_o=1, core_start_o never pulses, load then continues to beat 128.
//  4. rst at unload beat 30 -> all outputs 0 asynchronously; state LOAD, counters 0.
//  5. LANES=4 -> load_done_o after 32 beats; ad_o frozen after beat 10, data_o after beat 26.
//  6. Macro defined, decrypt: tag mismatch in 1 bit -> auth_ok_o=0, data_so all zeros;
//     exact match -> auth_ok_o=1, PT 0x6173636f6e2d756e6963617373 shifted out.

Source files
------------

// File: rtl/ascon_serial_io.sv
// Serial pin front-end for an Ascon AEAD core: shifts operands in LANES bits per strobe,
// starts the core, captures its result and shifts it back out. Optional tag check: ASCON_SERIAL_TAG_CHECK_EN.
module ascon_serial_io #(
  parameter int KEY_W   = 128,
  parameter int NONCE_W = 128,
  parameter int AD_W    = 40,
  parameter int DATA_W  = 104,
  parameter int TAG_W   = 128,
  parameter int LANES   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic [LANES-1:0]  key_si,
  input  logic [LANES-1:0]  nonce_si,
  input  logic [LANES-1:0]  ad_si,
  input  logic [LANES-1:0]  data_si,
  input  logic [LANES-1:0]  tag_si,
  input  logic              start_i,
  input  logic              decrypt_i,
  output logic [KEY_W-1:0]  key_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic [AD_W-1:0]   ad_o,
  output logic [DATA_W-1:0] data_o,
  output logic              decrypt_o,
  output logic              core_start_o,
  input  logic              core_ready_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic [TAG_W-1:0]  core_tag_i,
  output logic [LANES-1:0]  data_so,
  output logic [LANES-1:0]  tag_so,
  output logic              ready_so,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              err_o,
  output logic              auth_ok_o,
  output logic [1:0]        dbg_state
);

  localparam int MAX_KN  = (KEY_W > NONCE_W) ? KEY_W : NONCE_W;
  localparam int MAX_KNA = (MAX_KN > AD_W) ? MAX_KN : AD_W;
  localparam int MAX_OUT = (DATA_W > TAG_W) ? DATA_W : TAG_W;
  localparam int MAX_IN0 = (MAX_KNA > MAX_OUT) ? MAX_KNA : MAX_OUT;
  localparam int BEATS   = MAX_IN0 / LANES;
  localparam int CW      = $clog2(BEATS + 1);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] KEY_B   = CW'(KEY_W / LANES);
  localparam logic [CW-1:0] NONCE_B = CW'(NONCE_W / LANES);
  localparam logic [CW-1:0] AD_B    = CW'(AD_W / LANES);
  localparam logic [CW-1:0] DATA_B  = CW'(DATA_W / LANES);
  localparam logic [CW-1:0] TAG_B   = CW'(TAG_W / LANES);
  localparam logic [CW-1:0] OUT_B   = CW'(MAX_OUT / LANES);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic              start_q;
  logic              start_rise;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     ucnt;
  logic [DATA_W-1:0] data_sh;
  logic [TAG_W-1:0]  tag_sh;

  assign start_rise = start_i & ~start_q;
  assign busy_o     = (state == S_WAIT) || (state == S_UNLOAD);
  assign dbg_state  = state;
  assign data_so    = data_sh[DATA_W-1 -: LANES];
  assign tag_so     = tag_sh[TAG_W-1 -: LANES];

`ifdef ASCON_SERIAL_TAG_CHECK_EN
  logic [TAG_W-1:0] exp_tag;
  logic             tag_match;
  assign tag_match = (core_tag_i == exp_tag);
`else
  logic unused_tag;
  assign unused_tag = ^tag_si;
  assign auth_ok_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LOAD;
      start_q      <= 1'b0;
      cnt          <= '0;
      ucnt         <= '0;
      key_o        <= '0;
      nonce_o      <= '0;
      ad_o         <= '0;
      data_o       <= '0;
      decrypt_o    <= 1'b0;
      core_start_o <= 1'b0;
      data_sh      <= '0;
      tag_sh       <= '0;
      ready_so     <= 1'b0;
      load_done_o  <= 1'b0;
      err_o        <= 1'b0;
`ifdef ASCON_SERIAL_TAG_CHECK_EN
      exp_tag      <= '0;
      auth_ok_o    <= 1'b0;
`endif
    end else begin
      start_q      <= start_i;
      core_start_o <= 1'b0;
      case (state)
        S_LOAD: begin
          // Each stream stops at its own length; the beat counter saturates at the longest.
          if (shift_i && !load_done_o) begin
            if (cnt < KEY_B)   key_o   <= {key_o[KEY_W-LANES-1:0], key_si};
            if (cnt < NONCE_B) nonce_o <= {nonce_o[NONCE_W-LANES-1:0], nonce_si};
            if (cnt < AD_B)    ad_o    <= {ad_o[AD_W-LANES-1:0], ad_si};
            if (cnt < DATA_B)  data_o  <= {data_o[DATA_W-LANES-1:0], data_si};
`ifdef ASCON_SERIAL_TAG_CHECK_EN
            if (cnt < TAG_B)   exp_tag <= {exp_tag[TAG_W-LANES-1:0], tag_si};
`endif
            cnt         <= cnt + ONE;
            load_done_o <= (cnt + ONE == BEATS_C);
          end
          if (start_rise) begin
            if (load_done_o) begin
              state        <= S_WAIT;
              core_start_o <= 1'b1;
              decrypt_o    <= decrypt_i;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (start_rise) err_o <= 1'b1;
          if (core_ready_i) begin
`ifdef ASCON_SERIAL_TAG_CHECK_EN
            // A failed decrypt must never release its plaintext.
            if (decrypt_o) begin
              auth_ok_o <= tag_match;
              data_sh   <= tag_match ? core_data_i : '0;
            end else begin
              auth_ok_o <= 1'b0;
              data_sh   <= core_data_i;
            end
`else
            data_sh  <= core_data_i;
`endif
            tag_sh   <= core_tag_i;
            ready_so <= 1'b1;
            ucnt     <= '0;
            state    <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (start_rise) err_o <= 1'b1;
          if (shift_i) begin
            if (ucnt < DATA_B) data_sh <= {data_sh[DATA_W-LANES-1:0], {LANES{1'b0}}};
            if (ucnt < TAG_B)  tag_sh  <= {tag_sh[TAG_W-LANES-1:0], {LANES{1'b0}}};
            ucnt <= ucnt + ONE;
            if (ucnt + ONE == OUT_B) state <= S_DONE;
          end
        end
        default: begin
          // DONE: a start edge only re-arms loading; the core is not restarted.
          if (start_rise) begin
            state       <= S_LOAD;
            cnt         <= '0;
            ucnt        <= '0;
            load_done_o <= 1'b0;
            ready_so    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
